// File: rtl/reset_boot_sequencer_pkg.sv
// Shared types and helpers for the staged reset / boot sequencer.
package rst_seq_pkg;

    // Largest number of reset domains the sequencer can drive.
    localparam int MAX_DOMAINS = 8;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        STAGE    = 3'd1,
        RUN      = 3'd2,
        SW_HOLD  = 3'd3,
        SW_STAGE = 3'd4
    } seq_state_e;

    // Width of a down-counter able to hold the largest of three reload values.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return $clog2(m) + 1;
    endfunction

    // Isolates the lowest set bit of a domain vector (zero in, zero out).
    function automatic logic [MAX_DOMAINS-1:0] lowest_set(input logic [MAX_DOMAINS-1:0] v);
        return v & (~v + {{(MAX_DOMAINS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/reset_boot_sequencer_clk_en_divider.sv
// Clock-enable strobe and divided clock, free-running once reset has settled.
module clk_en_divider #(
    parameter int DIV_RATIO = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic clk_en,
    output logic clk_div
);

    localparam int DW = $clog2(DIV_RATIO) + 1;
    localparam logic [DW-1:0] LAST = DW'(DIV_RATIO - 1);

    if (DIV_RATIO < 1) begin : g_bad_div
        $error("clk_en_divider: DIV_RATIO must be >= 1");
    end

    logic [DW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          div_q, div_d;

    // Next-state: count to DIV_RATIO-1, strobe and toggle the divided clock on wrap.
    always_comb begin
        cnt_d = cnt_q;
        en_d  = 1'b0;
        div_d = div_q;
        if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = {DW{1'b0}};
                en_d  = 1'b1;
                div_d = ~div_q;
            end else begin
                cnt_d = cnt_q + {{(DW-1){1'b0}}, 1'b1};
                en_d  = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {DW{1'b0}};
            en_q  <= 1'b0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            div_q <= div_d;
        end
    end

    assign clk_en  = en_q;
    assign clk_div = div_q;

endmodule

// File: rtl/reset_boot_sequencer.sv
// Staged multi-domain reset generator with masked software reset and clock divider.
module reset_boot_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 2,
    parameter int CYCLES          = 20,
    parameter int STAGE_GAP       = 4,
    parameter int SW_RESET_CYCLES = 8,
    parameter int DIV_RATIO       = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sw_reset_req,
    input  logic [NUM_DOMAINS-1:0] sw_reset_mask,
    output logic [NUM_DOMAINS-1:0] reset_o,
    output logic                   clk_en,
    output logic                   clk_div,
    output logic                   ready,
    output logic                   busy,
    output logic                   sw_reset_ack
);

    localparam int CNT_W = cnt_width(CYCLES, STAGE_GAP, SW_RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0] SW_LOAD   = CNT_W'(SW_RESET_CYCLES);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONES = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] DOM_ZERO = {NUM_DOMAINS{1'b0}};

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_domains
        $error("reset_boot_sequencer: NUM_DOMAINS must be 1..8");
    end
    if (CYCLES < 1 || STAGE_GAP < 1 || SW_RESET_CYCLES < 1) begin : g_bad_timing
        $error("reset_boot_sequencer: CYCLES, STAGE_GAP, SW_RESET_CYCLES must be >= 1");
    end

    logic [1:0]             sync_q, sync_d;
    logic                   prev_req_q, prev_req_d;
    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] reset_o_q, reset_o_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic                   zero_ack_q, zero_ack_d;

    logic                   run_s;
    logic                   req_rise_s;
    logic                   expired_s;
    logic [NUM_DOMAINS-1:0] low_s;
    logic [NUM_DOMAINS-1:0] rel_s;

    assign run_s      = ~sync_q[1];
    assign req_rise_s = sw_reset_req & ~prev_req_q;
    assign expired_s  = (cnt_q <= CNT_ONE);
    // Domains still asserted are exactly the ones waiting for release, so the
    // next one to let go is always the lowest set bit of reset_o.
    assign low_s      = NUM_DOMAINS'(lowest_set(MAX_DOMAINS'(reset_o_q)));
    assign rel_s      = reset_o_q & ~low_s;

    // Reset-release synchroniser and request edge history.
    always_comb begin
        sync_d     = {sync_q[0], 1'b0};
        prev_req_d = sw_reset_req;
    end

    // Staging FSM: next state, shared down-counter and registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reset_o_d  = reset_o_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        zero_ack_d = 1'b0;
        if (run_s) begin
            if (cnt_q != {CNT_W{1'b0}}) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                HOLD, STAGE: begin
                    if (expired_s) begin
                        reset_o_d = rel_s;
                        cnt_d     = GAP_LOAD;
                        if (rel_s == DOM_ZERO) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = STAGE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                RUN: begin
                    if (zero_ack_q) begin
                        ack_d   = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (req_rise_s) begin
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        if (sw_reset_mask != DOM_ZERO) begin
                            reset_o_d = sw_reset_mask;
                            cnt_d     = SW_LOAD;
                            state_d   = SW_HOLD;
                        end else begin
                            zero_ack_d = 1'b1;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                SW_HOLD, SW_STAGE: begin
                    if (expired_s) begin
                        reset_o_d = rel_s;
                        cnt_d     = GAP_LOAD;
                        if (rel_s == DOM_ZERO) begin
                            state_d = RUN;
                            ack_d   = 1'b1;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = SW_STAGE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d   = HOLD;
                    cnt_d     = HOLD_LOAD;
                    reset_o_d = DOM_ONES;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sequencer state registers; asynchronous reset restarts the power-on hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            prev_req_q <= 1'b1;
            state_q    <= HOLD;
            cnt_q      <= HOLD_LOAD;
            reset_o_q  <= DOM_ONES;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
            zero_ack_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_req_q <= prev_req_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reset_o_q  <= reset_o_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            zero_ack_q <= zero_ack_d;
        end
    end

    clk_en_divider #(
        .DIV_RATIO (DIV_RATIO)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .run     (run_s),
        .clk_en  (clk_en),
        .clk_div (clk_div)
    );

    assign reset_o      = reset_o_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign sw_reset_ack = ack_q;

endmodule
